// File: rtl/rv32i_types.sv
// Shared RV32I core types: physical register index, free-list entry,
// rename packet bundle and rename-stage FSM states.
package rv32i_types;

    localparam int PREG_IDX_WIDTH = 6;

    typedef logic [PREG_IDX_WIDTH-1:0] free_list_entry_t;

    typedef struct packed {
        logic [PREG_IDX_WIDTH-1:0] ps1;
        logic                      ps1_valid;
        logic [PREG_IDX_WIDTH-1:0] ps2;
        logic                      ps2_valid;
        logic [PREG_IDX_WIDTH-1:0] pd;
        logic [4:0]                rd;
    } rename_pkt_t;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } rename_state_t;

endpackage

// File: rtl/free_list.sv
// Circular free list of physical registers with speculative and architectural
// heads. Ports: pop/push/push_pd/arch_adv/rewind in; head_pd/empty out.
module free_list
    import rv32i_types::*;
#(
    parameter int NUM_PREGS = 64,
    parameter int FL_PTR_W  = $clog2(NUM_PREGS - 32) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pop,
    input  logic             push,
    input  free_list_entry_t push_pd,
    input  logic             arch_adv,
    input  logic             rewind,
    output free_list_entry_t head_pd,
    output logic             empty
);

    localparam int DEPTH = NUM_PREGS - 32;
    localparam int IDX_W = FL_PTR_W - 1;

    typedef logic [FL_PTR_W-1:0] ptr_t;

    // Advance a pointer, toggling the wrap bit when the index rolls over.
    function automatic ptr_t ptr_inc(input ptr_t p);
        if (p[IDX_W-1:0] == IDX_W'(DEPTH - 1))
            return {~p[FL_PTR_W-1], {IDX_W{1'b0}}};
        else
            return p + ptr_t'(1);
    endfunction

    free_list_entry_t fl [DEPTH];
    ptr_t spec_head;
    ptr_t arch_head;
    ptr_t tail;
    ptr_t arch_nxt;
    logic full;

    assign arch_nxt = arch_adv ? ptr_inc(arch_head) : arch_head;
    assign head_pd  = fl[spec_head[IDX_W-1:0]];
    assign empty    = (tail == spec_head);
    assign full     = (tail[FL_PTR_W-1] != spec_head[FL_PTR_W-1]) &&
                      (tail[IDX_W-1:0] == spec_head[IDX_W-1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                fl[i] <= free_list_entry_t'(32 + i);
            spec_head <= '0;
            arch_head <= '0;
            tail      <= {1'b1, {IDX_W{1'b0}}};
        end else begin
            arch_head <= arch_nxt;
            // Rewind lands on the head including a same-cycle commit.
            if (rewind)
                spec_head <= arch_nxt;
            else if (pop)
                spec_head <= ptr_inc(spec_head);
            if (push) begin
                fl[tail[IDX_W-1:0]] <= push_pd;
                tail                <= ptr_inc(tail);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n)
            assert (!(push && full))
            else $error("free_list: push while full");
    end

endmodule

// File: rtl/rename_ctrl.sv
// Rename stage control: RAT lookup, preg allocation, ROB/RS issue and
// flush recovery. Ports: decode handshake, RAT, ROB/RS, commit, flush.
module rename_ctrl
    import rv32i_types::*;
#(
    parameter int NUM_PREGS = 64,
    parameter int FL_PTR_W  = $clog2(NUM_PREGS - 32) + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      inst_valid,
    output logic                      inst_ready,
    input  logic [4:0]                inst_rd,
    input  logic [4:0]                inst_rs1,
    input  logic [4:0]                inst_rs2,
    input  logic                      inst_has_rd,
    output logic [4:0]                rat_rs1,
    output logic [4:0]                rat_rs2,
    input  logic [PREG_IDX_WIDTH-1:0] rat_ps1,
    input  logic [PREG_IDX_WIDTH-1:0] rat_ps2,
    input  logic                      rat_ps1_valid,
    input  logic                      rat_ps2_valid,
    output logic [4:0]                rat_rd,
    output logic [PREG_IDX_WIDTH-1:0] rat_pd,
    output logic                      rat_we,
    input  logic                      rob_ready,
    input  logic                      rs_ready,
    output logic                      rob_alloc,
    output logic                      rs_push,
    output logic [PREG_IDX_WIDTH-1:0] rs_ps1,
    output logic                      rs_ps1_valid,
    output logic [PREG_IDX_WIDTH-1:0] rs_ps2,
    output logic                      rs_ps2_valid,
    output logic [PREG_IDX_WIDTH-1:0] rs_pd,
    input  logic                      commit_valid,
    input  logic                      commit_has_rd,
    input  logic [PREG_IDX_WIDTH-1:0] commit_old_pd,
    input  logic                      branch_flush,
    output logic                      fl_empty
);

    rename_state_t    state;
    rename_state_t    state_nxt;
    rename_pkt_t      pkt;
    free_list_entry_t head_pd;
    logic             needs_pd;
    logic             fire;
    logic             pop;
    logic             push;
    logic             arch_adv;

    assign needs_pd = inst_has_rd && (inst_rd != 5'd0);
    assign arch_adv = commit_valid && commit_has_rd;
    assign push     = arch_adv && (commit_old_pd != '0);

    // rst_n gating keeps every handshake low while reset is held.
    assign inst_ready = rst_n && (state == RUN) && !branch_flush &&
                        rob_ready && rs_ready && (!needs_pd || !fl_empty);
    assign fire       = inst_valid && inst_ready;
    assign pop        = fire && needs_pd;

    free_list #(
        .NUM_PREGS (NUM_PREGS),
        .FL_PTR_W  (FL_PTR_W)
    ) u_free_list (
        .clk      (clk),
        .rst_n    (rst_n),
        .pop      (pop),
        .push     (push),
        .push_pd  (commit_old_pd),
        .arch_adv (arch_adv),
        .rewind   (branch_flush),
        .head_pd  (head_pd),
        .empty    (fl_empty)
    );

    always_comb begin
        pkt           = '0;
        pkt.ps1       = rat_ps1;
        pkt.ps1_valid = rat_ps1_valid;
        pkt.ps2       = rat_ps2;
        pkt.ps2_valid = rat_ps2_valid;
        pkt.rd        = inst_rd;
        pkt.pd        = needs_pd ? head_pd : '0;
    end

    assign rat_rs1      = inst_rs1;
    assign rat_rs2      = inst_rs2;
    assign rat_rd       = pkt.rd;
    assign rat_pd       = pkt.pd;
    assign rat_we       = pop;
    assign rob_alloc    = fire;
    assign rs_push      = fire;
    assign rs_ps1       = pkt.ps1;
    assign rs_ps1_valid = pkt.ps1_valid;
    assign rs_ps2       = pkt.ps2;
    assign rs_ps2_valid = pkt.ps2_valid;
    assign rs_pd        = pkt.pd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= RUN;
        else
            state <= state_nxt;
    end

    // RECOVER gives the alias table one cycle to reload.
    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN:     if (branch_flush) state_nxt = RECOVER;
            RECOVER: state_nxt = branch_flush ? RECOVER : RUN;
            default: state_nxt = RUN;
        endcase
    end

endmodule
